bram_read_streamer: RTL and testbench

- Downstream consumer of the single-port BRAM (DATA_WIDTH x 2^ADDR_WIDTH, 1-cycle registered read).
- On a start command, issues sequential BRAM reads from a base address for a given length.
- Presents each word on a valid/ready stream with a last marker.
- A 2-entry output buffer absorbs the read latency and downstream backpressure without losing or duplicating words.

---
 rtl/bram_read_streamer.sv | 172 +++++++++++++++++
 tb/tb_bram_read_streamer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/bram_read_streamer.sv
// Streams a block of sequential BRAM words onto a valid/ready interface.
// A 2-entry output buffer covers the 1-cycle read latency and downstream stalls.
module bram_read_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_read_enable,
  output logic [ADDR_WIDTH-1:0] bram_address,
  input  logic [DATA_WIDTH-1:0] bram_data_out,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_WIDTH:0]   LEN_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_r;
  logic [ADDR_WIDTH-1:0]  addr_r;
  logic [ADDR_WIDTH-1:0]  last_addr_r;
  logic [ADDR_WIDTH:0]    rem_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   inflight_r;
  logic                   inflight_last_r;
  logic [1:0]             count_r;
  logic [DATA_WIDTH-1:0]  head_data_r;
  logic [DATA_WIDTH-1:0]  tail_data_r;
  logic                   head_last_r;
  logic                   tail_last_r;

  logic                   pop_s;
  logic                   push_s;
  logic                   issue_s;
  logic [1:0]             occ_s;

  // Reads are issued combinationally so a pop in the same cycle frees a slot;
  // this is what lets a 2-entry buffer sustain one beat per cycle.
  assign pop_s   = (count_r != 2'd0) && m_ready;
  assign push_s  = inflight_r;
  assign occ_s   = count_r + {1'b0, inflight_r};
  assign issue_s = (state_r == S_RUN) && (rem_r != LEN_ZERO) && ((occ_s < 2'd2) || pop_s);

  assign bram_read_enable = issue_s;
  assign bram_address     = issue_s ? addr_r : last_addr_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign m_valid          = (count_r != 2'd0);
  assign m_data           = head_data_r;
  assign m_last           = head_last_r;

  // Command FSM: address/length tracking, busy and done generation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= S_IDLE;
      addr_r      <= {ADDR_WIDTH{1'b0}};
      last_addr_r <= {ADDR_WIDTH{1'b0}};
      rem_r       <= LEN_ZERO;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            if (length != LEN_ZERO) begin
              state_r <= S_RUN;
              busy_r  <= 1'b1;
              addr_r  <= base_addr;
              rem_r   <= length;
            end else begin
              state_r <= S_DONE;
              done_r  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (issue_s) begin
            last_addr_r <= addr_r;
            addr_r      <= addr_r + ADDR_ONE;
            rem_r       <= rem_r - LEN_ONE;
            if (rem_r == LEN_ONE) begin
              state_r <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // The last-tagged word is the final one in flight, so its pop
          // implies the buffer and read pipeline are empty.
          if (pop_s && head_last_r) begin
            state_r <= S_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Read pipeline: remembers which edge returns data and whether it is the last word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
    end else begin
      inflight_r      <= issue_s;
      inflight_last_r <= issue_s && (rem_r == LEN_ONE);
    end
  end

  // Two-entry output FIFO; head is always the presented beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r     <= 2'd0;
      head_data_r <= {DATA_WIDTH{1'b0}};
      tail_data_r <= {DATA_WIDTH{1'b0}};
      head_last_r <= 1'b0;
      tail_last_r <= 1'b0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            head_data_r <= bram_data_out;
            head_last_r <= inflight_last_r;
          end else begin
            tail_data_r <= bram_data_out;
            tail_last_r <= inflight_last_r;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          head_data_r <= tail_data_r;
          head_last_r <= tail_last_r;
          count_r     <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            head_data_r <= bram_data_out;
            head_last_r <= inflight_last_r;
          end else begin
            head_data_r <= tail_data_r;
            head_last_r <= tail_last_r;
            tail_data_r <= bram_data_out;
            tail_last_r <= inflight_last_r;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_read_streamer.sv
// Directed scoreboard bench for bram_read_streamer with a behavioural BRAM.
module tb_bram_read_streamer;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy, done, bram_read_enable;
  logic [AW-1:0] bram_address;
  logic [DW-1:0] bram_data_out = 8'd0;
  logic          m_valid, m_ready, m_last;
  logic [DW-1:0] m_data;

  logic [DW-1:0] mem [DEPTH];
  beat_t         exp_q[$];
  logic [AW-1:0] addr_q[$];
  int            compared   = 0;
  int            mismatched = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram_read_enable) bram_data_out <= mem[bram_address];
  end

  bram_read_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .bram_read_enable(bram_read_enable),
    .bram_address(bram_address), .bram_data_out(bram_data_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic rdy(input int mode, input int c);
    logic [5:0] pat;
    pat = 6'b101001;
    return (mode == 0) ? 1'b1 : pat[c % 6];
  endfunction

  task automatic run_cmd(input logic [AW-1:0] b, input int len, input int mode,
                         input int abort_after, input bit restart);
    int    cyc = 0, issued = 0, accepted = 0, dones = 0;
    int    done_cyc = -1, last_cyc = -1, first_valid = -1;
    bit    pv = 1'b0, pr = 1'b0, pop_now, fin = 1'b0;
    logic [DW-1:0] pd = 8'd0;
    logic  pl = 1'b0;
    beat_t e;
    for (int i = 0; i < len; i++) begin
      e.data = mem[(int'(b) + i) % DEPTH];
      e.last = (i == len - 1);
      exp_q.push_back(e);
      addr_q.push_back(AW'((int'(b) + i) % DEPTH));
    end
    @(negedge clk);
    start = 1'b1; base_addr = b; length = (AW+1)'(len); m_ready = rdy(mode, 0);
    while (!fin) begin
      @(negedge clk);
      cyc++;
      start   = (restart && cyc == 5);
      if (restart && cyc == 5) begin base_addr = 4'd0; length = 5'd16; end
      m_ready = rdy(mode, cyc);
      if (abort_after >= 0 && accepted == abort_after) begin
        rst = 1'b0;
        #1;
        check("abort_outputs", {busy, done, bram_read_enable, m_valid, m_last, bram_address, m_data}, 32'd0);
        exp_q.delete();
        addr_q.delete();
        repeat (4) begin
          @(negedge clk);
          check("abort_no_done", {done, m_valid, busy}, 32'd0);
        end
        rst = 1'b1;
        fin = 1'b1;
      end else begin
        #1;
        pop_now = m_valid && m_ready;
        if (bram_read_enable) begin
          check("read_window", ((issued - accepted) < 2) || pop_now, 32'd1);
          if (addr_q.size() == 0) check("extra_read", bram_address, 32'hFFFF);
          else check("bram_address", bram_address, addr_q.pop_front());
          issued++;
        end
        if (pv && !pr) check("stall_hold", {m_valid, m_data, m_last}, {1'b1, pd, pl});
        if (m_valid && first_valid < 0) first_valid = cyc;
        if (pop_now) begin
          if (exp_q.size() == 0) check("extra_beat", {m_data, m_last}, 32'hFFFF);
          else begin
            e = exp_q.pop_front();
            check("beat", {m_data, m_last}, {e.data, e.last});
          end
          accepted++;
          if (m_last) last_cyc = cyc;
        end
        if (done) begin
          dones++;
          done_cyc = cyc;
          check("done_timing", cyc, (len == 0) ? 1 : last_cyc + 1);
          check("busy_at_done", busy, 32'd0);
        end
        if (cyc == 1) check("busy_start", busy, (len != 0));
        pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
        if (done_cyc >= 0 && cyc >= done_cyc + 4) fin = 1'b1;
        if (cyc >= 300) begin
          check("timeout", cyc, 32'd0);
          fin = 1'b1;
        end
      end
    end
    if (abort_after < 0) begin
      check("done_count", dones, 32'd1);
      check("beats_accepted", accepted, len);
      check("beats_left", exp_q.size(), 32'd0);
      check("reads_left", addr_q.size(), 32'd0);
      if (mode == 0 && len > 0) check("first_valid_cycle", first_valid, 32'd3);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 1);
    rst = 1'b0; start = 1'b0; base_addr = 4'd0; length = 5'd0; m_ready = 1'b0;
    #12;
    check("reset_outputs", {busy, done, bram_read_enable, m_valid, m_last, bram_address, m_data}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_cmd(4'd0,  16, 0, -1, 1'b0);
    run_cmd(4'd14, 4,  0, -1, 1'b0);
    run_cmd(4'd0,  8,  1, -1, 1'b0);
    run_cmd(4'd0,  0,  0, -1, 1'b0);
    run_cmd(4'd0,  16, 0, -1, 1'b1);
    run_cmd(4'd0,  16, 0, 5,  1'b0);
    run_cmd(4'd3,  2,  0, -1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
